bram_sr_delay_line: RTL and testbench
=====================================

BRAM_SR_DELAY_LINE -- requirements
Module: bram_sr_delay_line

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, sample width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, buffer address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1 << ADDR_WIDTH, delay length in samples.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of the stream state; memory contents untouched.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  input sample.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  delayed sample.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-013 SHALL have port fill_count  output  ADDR_WIDTH+1  samples written since reset/flush, saturating at RAM_DEPTH.
REQ-014 SHALL have port primed  output  1  high when fill_count == RAM_DEPTH.

Function
REQ-015 Accept SHALL be defined as in_valid && in_ready.
REQ-016 in_ready SHALL equal !flush && (!out_valid || out_ready), combinationally.
REQ-017 On accept, the block SHALL read slot wr_ptr (old contents) and write in_data to slot wr_ptr in the same cycle, read-first.
REQ-018 wr_ptr SHALL increment by one on each accept and wrap from RAM_DEPTH-1 to 0.
REQ-019 fill_count SHALL increment on each accept until it reaches RAM_DEPTH, then hold.
REQ-020 An accept when primed was already 1 SHALL set out_valid on the next cycle, with out_data equal to the sample accepted RAM_DEPTH accepts earlier.
REQ-021 An accept when primed was 0 SHALL produce no output (see REQ-029).
REQ-022 out_valid SHALL clear on the cycle after out_valid && out_ready when no new output is generated on that cycle.
REQ-023 Output latency SHALL be exactly one cycle from accept to out_valid.
REQ-024 Full throughput SHALL be one sample per cycle when out_ready is held high.
REQ-025 While out_valid && !out_ready, out_data SHALL stay stable and the RAM read SHALL be disabled.
REQ-026 flush SHALL clear wr_ptr, fill_count and out_valid on the next edge.
REQ-027 When flush and in_valid are both high, flush SHALL take priority and the input SHALL be dropped.
REQ-028 After a flush, pre-flush memory contents SHALL never appear on out_data while primed is 0.

Reset
REQ-029 reset SHALL set out_valid=0, out_data=0, fill_count=0, primed=0 and wr_ptr=0 on the next edge; in_ready=1 on the cycle after reset deasserts.
REQ-030 Reset asserted mid-stream SHALL behave as flush and override all other inputs; memory contents after reset SHALL be don't-care.

Configuration
REQ-031 Macro BRAM_SR_ZERO_PRIME_EN, when defined: each accept made while primed=0 SHALL produce one output with out_data=0, following REQ-020/023 timing, giving a zero-initialised delay line.
REQ-032 Without BRAM_SR_ZERO_PRIME_EN, outputs SHALL be produced only per REQ-020/021.

Structure
REQ-033 Package bram_sr_pkg SHALL hold the default DATA_WIDTH and ADDR_WIDTH constants and the fill-count width function.
REQ-034 Sub-module bram_sp_rf SHALL implement the storage as a single-port, read-first, registered-output RAM with read enable, inferable as BRAM; no reset on the array.

Verification (ADDR_WIDTH=2, RAM_DEPTH=4)
REQ-035 Reset, then idle -> out_valid=0, fill_count=0, primed=0, in_ready=1.
REQ-036 Inputs 1..8 on consecutive cycles, out_ready=1 -> no output for 1..4; primed=1 after the 4th accept; outputs 1,2,3,4 one cycle after accepting 5,6,7,8.
REQ-037 Primed, out_ready=0 while out_valid=1 -> in_ready=0, out_data held; release out_ready -> stream resumes with no loss or duplication.
REQ-038 Flush after 6 inputs, then inputs 9..12 -> fill_count=0 after the flush, no outputs for 9..12, primed=1 after 12; the next input yields 9.
REQ-039 Inputs 1..12 with random out_ready stalls -> outputs exactly 1..8 in order, fill_count saturates at 4, wr_ptr wraps cleanly.
REQ-040 With BRAM_SR_ZERO_PRIME_EN defined, inputs 1..8 -> outputs 0,0,0,0,1,2,3,4.

Source files
------------

// File: rtl/bram_sr_pkg.sv
// Shared constants and helpers for the BRAM-backed shift-register delay line.
package bram_sr_pkg;

  localparam int DEFAULT_DATA_WIDTH = 9;
  localparam int DEFAULT_ADDR_WIDTH = 9;

  // One extra bit so the count can reach RAM_DEPTH itself.
  function automatic int fill_count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bram_sp_rf.sv
// Single-port, read-first RAM with registered output and read enable.
// The array has no reset so synthesis can map it onto block RAM.
module bram_sp_rf #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first: rdata gets the old contents of the slot being overwritten.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_sr_delay_line.sv
// Fixed-length sample delay line built on a read-first BRAM with valid/ready streaming.
// Optional macro BRAM_SR_ZERO_PRIME_EN: emit zeros while filling (zero-initialised line).
module bram_sr_delay_line
  import bram_sr_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [fill_count_width(ADDR_WIDTH)-1:0] fill_count,
  output logic                                    primed
);

  localparam int FILL_W = fill_count_width(ADDR_WIDTH);

`ifdef BRAM_SR_ZERO_PRIME_EN
  localparam bit ZERO_PRIME = 1'b1;
`else
  localparam bit ZERO_PRIME = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  accept;
  logic                  gen;
  logic                  zero_sel;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !reset;
  assign primed   = (fill_count == FILL_W'(RAM_DEPTH));
  assign gen      = accept && (primed || ZERO_PRIME);

  // The RAM only reads on accept, so a stalled output keeps its registered data.
  bram_sp_rf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (RAM_DEPTH)
  ) u_ram (
    .clock (clock),
    .en    (accept),
    .we    (accept),
    .addr  (wr_ptr),
    .wdata (in_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
      zero_sel   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (!primed) begin
          fill_count <= fill_count + 1'b1;
        end
      end
      if (gen) begin
        out_valid <= 1'b1;
        zero_sel  <= !primed;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Masking hides stale RAM contents (pre-flush or post-reset) and yields zeros while priming.
  assign out_data = (out_valid && !zero_sel) ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_sr_delay_line.sv
// Directed bench for bram_sr_delay_line at ADDR_WIDTH=2 (four-sample delay).
// Expected outputs follow BRAM_SR_ZERO_PRIME_EN when it is defined for the build.
module tb_bram_sr_delay_line;

  localparam int DW = 9;
  localparam int AW = 2;
  localparam int DEPTH = 4;

`ifdef BRAM_SR_ZERO_PRIME_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW:0]   fill_count;
  logic          primed;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  bit stall_en = 1'b0;
  logic [15:0] stall_pat = 16'b1011_0010_1100_1101;
  int pat_idx = 0;

  bram_sr_delay_line #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_count (fill_count),
    .primed     (primed)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshakes are observed at the falling edge; inputs change 1 time unit after the rising edge.
  task automatic tick(output bit acc);
    @(negedge clock);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("spurious_out", out_valid, 0);
      else checkOutput("out_data", out_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int data, output int waits);
    bit acc = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data = DW'(data);
    for (int n = 0; n < 64; n++) begin
      if (stall_en) begin
        out_ready = stall_pat[pat_idx % 16];
        pat_idx++;
      end
      tick(acc);
      if (acc) break;
      waits++;
    end
    if (!acc) checkOutput("accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    stall_en = 1'b0;
    for (int n = 0; n < 4; n++) tick(acc);
    checkOutput("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bit acc;
    reset = 1'b1;
    for (int n = 0; n < 2; n++) tick(acc);
    reset = 1'b0;
    tick(acc);
  endtask

  task automatic push_zeros(input int n);
    if (ZP) for (int i = 0; i < n; i++) exp_q.push_back(0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int waits;
    bit acc;

    // Reset and idle state
    do_reset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_fill", fill_count, 0);
    checkOutput("rst_primed", primed, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_data", out_data, 0);

    // 1..8 back-to-back, full throughput
    push_zeros(4);
    for (int v = 1; v <= 4; v++) exp_q.push_back(v);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(i, waits);
      checkOutput("tput_waits", waits, 0);
      checkOutput("fill", fill_count, (i < 4) ? i : 4);
      checkOutput("primed", primed, (i >= 4) ? 1 : 0);
      checkOutput("latency_valid", out_valid, (i >= 5 || ZP) ? 1 : 0);
    end
    drain();

    // Output backpressure holds data and blocks input
    exp_q.push_back(5);
    out_ready = 1'b0;
    applyStimulus(9, waits);
    in_valid = 1'b1;
    in_data = DW'(10);
    #1;
    for (int n = 0; n < 3; n++) begin
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_data", out_data, 5);
      tick(acc);
    end
    out_ready = 1'b1;
    for (int v = 6; v <= 8; v++) exp_q.push_back(v);
    for (int i = 10; i <= 12; i++) applyStimulus(i, waits);
    drain();

    // Flush mid-stream with a dropped concurrent input
    do_reset();
    push_zeros(4);
    exp_q.push_back(1);
    exp_q.push_back(2);
    for (int i = 1; i <= 6; i++) applyStimulus(i, waits);
    drain();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = DW'(99);
    #1;
    checkOutput("flush_in_ready", in_ready, 0);
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_fill", fill_count, 0);
    checkOutput("flush_primed", primed, 0);
    checkOutput("flush_valid", out_valid, 0);
    push_zeros(4);
    exp_q.push_back(9);
    for (int i = 9; i <= 12; i++) begin
      applyStimulus(i, waits);
      checkOutput("post_flush_valid", out_valid, ZP ? 1 : 0);
    end
    checkOutput("post_flush_primed", primed, 1);
    applyStimulus(13, waits);
    drain();

    // Irregular output stalls across pointer wrap
    do_reset();
    push_zeros(4);
    for (int v = 1; v <= 8; v++) exp_q.push_back(v);
    stall_en = 1'b1;
    for (int i = 1; i <= 12; i++) applyStimulus(i, waits);
    checkOutput("sat_fill", fill_count, 4);
    checkOutput("sat_primed", primed, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
